// File: rtl/uart_frame_ctrl.sv
// Byte-stream frame parser: SYNC(0xA5) ADDR LEN payload [CSUM], replayed as wr_en bursts.
// Define UART_FRAME_CSUM_EN to receive and check the trailing XOR checksum byte.
module uart_frame_ctrl #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD_RATE     = 9600,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [3:0] wr_idx,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int TIMEOUT    = TIMEOUT_BYTES * 10 * BIT_PERIOD;
    localparam int TW         = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef UART_FRAME_CSUM_EN
        S_CSUM,
`endif
        S_FLUSH
    } state_t;

`ifdef UART_FRAME_CSUM_EN
    localparam state_t S_BODY_END = S_CSUM;
`else
    localparam state_t S_BODY_END = S_FLUSH;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_addr;
    logic [7:0]      r_len;
    logic [4:0]      r_cnt;
    logic [7:0]      r_buf [0:15];
    logic            r_wr_en;
    logic [7:0]      r_wr_addr;
    logic [3:0]      r_wr_idx;
    logic [7:0]      r_wr_data;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic            w_active;
    logic            w_tmo;
    logic            w_rx;
    logic            w_err_set;
    logic [1:0]      w_err_nxt;
    logic            w_done_set;
    logic            w_wr_set;
    logic            w_store;
    logic            w_lat_addr;
    logic            w_lat_len;

    // Timeout wins over a byte arriving in the same cycle.
    assign w_active = (r_state != S_HUNT) && (r_state != S_FLUSH);
    assign w_tmo    = w_active && (r_tmo == TW'(TIMEOUT - 1));
    assign w_rx     = rx_ready && !w_tmo;

`ifdef UART_FRAME_CSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xor <= '0;
        end else if (r_state == S_HUNT) begin
            r_xor <= '0;
        end else if (w_lat_addr || w_lat_len || w_store) begin
            r_xor <= r_xor ^ rx_data;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_err_nxt   = 2'b00;
        w_done_set  = 1'b0;
        w_wr_set    = 1'b0;
        w_store     = 1'b0;
        w_lat_addr  = 1'b0;
        w_lat_len   = 1'b0;
        if (w_tmo) begin
            w_err_set   = 1'b1;
            w_err_nxt   = 2'b11;
            w_state_nxt = S_HUNT;
        end else begin
            case (r_state)
                S_HUNT: begin
                    if (w_rx && rx_data == SYNC) w_state_nxt = S_ADDR;
                end
                S_ADDR: begin
                    if (w_rx) begin
                        w_lat_addr  = 1'b1;
                        w_state_nxt = S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_rx) begin
                        w_lat_len = 1'b1;
                        if (rx_data > 8'(MAX_LEN)) begin
                            w_err_set   = 1'b1;
                            w_err_nxt   = 2'b01;
                            w_state_nxt = S_HUNT;
                        end else if (rx_data == 8'd0) begin
                            w_state_nxt = S_BODY_END;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx) begin
                        w_store = 1'b1;
                        if (8'(r_cnt) + 8'd1 == r_len) w_state_nxt = S_BODY_END;
                    end
                end
`ifdef UART_FRAME_CSUM_EN
                S_CSUM: begin
                    if (w_rx) begin
                        if (rx_data == r_xor) begin
                            w_state_nxt = S_FLUSH;
                        end else begin
                            w_err_set   = 1'b1;
                            w_err_nxt   = 2'b10;
                            w_state_nxt = S_HUNT;
                        end
                    end
                end
`endif
                // Bytes arriving here are dropped; replay runs to completion.
                S_FLUSH: begin
                    if (8'(r_cnt) == r_len) begin
                        w_done_set  = 1'b1;
                        w_state_nxt = S_HUNT;
                    end else begin
                        w_wr_set = 1'b1;
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_HUNT;
            r_tmo      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_idx   <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= (rx_ready || !w_active) ? '0 : r_tmo + 1'b1;
            r_wr_en <= w_wr_set;
            r_done  <= w_done_set;
            r_err   <= w_err_set;
            if (w_err_set)  r_err_code <= w_err_nxt;
            if (w_lat_addr) r_addr     <= rx_data;
            if (w_lat_len)  r_len      <= rx_data;
            if (w_wr_set) begin
                r_wr_addr <= r_addr;
                r_wr_idx  <= r_cnt[3:0];
                r_wr_data <= r_buf[r_cnt[3:0]];
            end
            // Index restarts for the replay pass and whenever the frame ends.
            if (w_lat_len || w_state_nxt == S_HUNT ||
                (w_state_nxt == S_FLUSH && r_state != S_FLUSH)) begin
                r_cnt <= '0;
            end else if (w_store || w_wr_set) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_buf[r_cnt[3:0]] <= rx_data;
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_idx     = r_wr_idx;
    assign wr_data    = r_wr_data;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign err_code   = r_err_code;
    assign busy       = (r_state != S_HUNT);
endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset_n, which is asynchronous and active-low.
REQ-002 Parameter CLK_FREQ, default 50000000, SHALL give the clk frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 9600, SHALL give the line rate, with BIT_PERIOD = CLK_FREQ / BAUD_RATE.
REQ-004 Parameter MAX_LEN, default 16, SHALL give the maximum payload bytes per frame (1..16).
REQ-005 Parameter TIMEOUT_BYTES, default 4, SHALL give the inter-byte timeout in byte times; TIMEOUT = TIMEOUT_BYTES*10*BIT_PERIOD clocks.
REQ-006 Ports SHALL be, clock and reset first, as name / direction / width / meaning:
- clk / in / 1 / clock.
- reset_n / in / 1 / async active-low reset.
- rx_data / in / 8 / byte from the UART receiver.
- rx_ready / in / 1 / one-cycle pulse, rx_data valid.
- wr_en / out / 1 / payload write strobe.
- wr_addr / out / 8 / frame ADDR byte.
- wr_idx / out / 4 / payload byte index.
- wr_data / out / 8 / payload byte.
- frame_done / out / 1 / one-cycle pulse, frame accepted.
- frame_err / out / 1 / one-cycle pulse, frame rejected.
- err_code / out / 2 / reason, valid with frame_err.
- busy / out / 1 / high when not in HUNT.

Function
REQ-007 Frame format SHALL be SYNC (0xA5), ADDR, LEN, LEN payload bytes, then CSUM, where CSUM = XOR of ADDR, LEN and all payload bytes.
REQ-008 The state machine SHALL have states HUNT, ADDR, LEN, DATA, CSUM and FLUSH.
- HUNT: waits for a byte; 0xA5 goes to ADDR, any other byte is discarded.
- ADDR: the next byte is latched as the address, then go to LEN.
- LEN: the next byte is latched as the length.
REQ-009 In LEN, the length byte SHALL be handled as follows:
- LEN > MAX_LEN: frame_err with err_code=2'b01, next cycle, then HUNT.
- LEN = 0: go to CSUM.
- Otherwise: go to DATA.
REQ-010 DATA SHALL store each byte into an internal 16x8 buffer at the running index, and go to CSUM after byte LEN.
REQ-011 In CSUM, a match SHALL go to FLUSH; a mismatch SHALL pulse frame_err with err_code=2'b10 and go to HUNT.
REQ-012 FLUSH SHALL assert wr_en for LEN consecutive cycles with wr_idx 0..LEN-1, wr_data from the buffer, and wr_addr = ADDR.
REQ-013 frame_done SHALL pulse on the cycle after the last wr_en (or the cycle after CSUM if LEN=0), with return to HUNT on that same cycle.
REQ-014 The running XOR SHALL be 8-bit, cleared on SYNC acceptance, and SHALL not include SYNC or CSUM.
REQ-015 A timeout counter SHALL clear on every rx_ready; if it reaches TIMEOUT in ADDR, LEN, DATA or CSUM, frame_err with err_code=2'b11 SHALL pulse and the state SHALL return to HUNT.
REQ-016 rx_ready during FLUSH SHALL be dropped (no state effect); rx_ready in the same cycle as a timeout expiry SHALL be ignored, with the timeout taking priority.
REQ-017 No wr_en SHALL ever be asserted for a rejected frame; frame_done and frame_err SHALL never be high together.
REQ-018 wr_en, frame_done and frame_err SHALL be registered outputs; wr_addr, wr_idx and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-019 On reset_n low, the block SHALL immediately enter HUNT; all outputs SHALL be 0, and the counters, XOR and buffer index SHALL be 0.
REQ-020 Reset during FLUSH SHALL abort the frame, with no frame_done, and the first byte after release SHALL be treated in HUNT.

Configuration
REQ-021 With UART_FRAME_CSUM_EN defined, the CSUM byte SHALL be received and checked per REQ-011.
REQ-022 Without UART_FRAME_CSUM_EN, the CSUM state SHALL be omitted: after the last payload byte, or after LEN=0, go directly to FLUSH; err_code 2'b10 SHALL never occur.

Verification (CSUM_EN defined, defaults)
REQ-023 The bench SHALL cover the following directed scenarios:
- Bytes A5 03 02 11 22 32 -> wr_en on 2 cycles: (idx0, 0x11) then (idx1, 0x22), addr 0x03, then frame_done.
- Bytes A5 03 02 11 22 33 -> frame_err with err_code 10; no wr_en.
- Bytes 00 FF 7E A5 07 00 07 -> junk ignored; frame_done; no wr_en.
- Bytes A5 01 20 -> frame_err with err_code 01 after LEN; back in HUNT, busy=0.
- Bytes A5 03, then silence -> frame_err with err_code 11 exactly TIMEOUT clocks after the 0x03 rx_ready.
- reset_n pulsed low mid-FLUSH -> outputs 0 immediately; no frame_done.
